// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory read handshake between the fetch unit (master) and imem (slave).
interface pc_fetch_unit_if #(parameter int ADDR_W = 32);
  logic              imem_read;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_readdata;
  logic              imem_busywait;
  modport master (output imem_read, imem_addr, input imem_readdata, imem_busywait);
  modport slave  (input imem_read, imem_addr, output imem_readdata, imem_busywait);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC owner and imem fetch front end feeding the IF register; FETCH_PERF_CNT_EN adds fetch/stall counters.
module pc_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              branch_jump_signal,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              busywait,
  input  logic              hold,
  pc_fetch_unit_if.master   imem,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_4_out,
  output logic [31:0]       instruction_out,
  output logic              busywait_imem
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [31:0]       stall_count
`endif
);
  localparam logic [1:0] RST = 2'd0, FETCH = 2'd1, DISCARD = 2'd2, BUFFERED = 2'd3;
  logic [1:0]        state;
  logic [ADDR_W-1:0] pc, fetch_addr, pc_4;
  logic [31:0]       ibuf;
  logic              stall, br, ibw, fetch_valid, done;
  always_comb begin
    stall           = busywait | hold;
    br              = branch_jump_signal;
    ibw             = imem.imem_busywait;
    pc_4            = pc + ADDR_W'(4);
    done            = (state == FETCH) & ~ibw;
    fetch_valid     = done | (state == BUFFERED);
    imem.imem_read  = (state == FETCH) | (state == DISCARD);
    imem.imem_addr  = fetch_addr;
    pc_out          = pc;
    pc_4_out        = pc_4;
    instruction_out = done ? imem.imem_readdata : (state == BUFFERED) ? ibuf : 32'd0;
    busywait_imem   = ~fetch_valid;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RST;
      pc         <= RESET_PC;
      fetch_addr <= RESET_PC;
      ibuf       <= '0;
    end else begin
      case (state)
        RST: state <= FETCH;
        FETCH:
          if (br) begin
            pc <= branch_target;
            if (ibw) state <= DISCARD;
            else fetch_addr <= branch_target;
          end else if (!ibw) begin
            if (stall) begin
              ibuf  <= imem.imem_readdata;
              state <= BUFFERED;
            end else begin
              pc         <= pc_4;
              fetch_addr <= pc_4;
            end
          end
        DISCARD: begin
          if (br) pc <= branch_target;
          if (!ibw) begin
            fetch_addr <= br ? branch_target : pc;
            state      <= FETCH;
          end
        end
        default:
          if (br || !stall) begin
            pc         <= br ? branch_target : pc_4;
            fetch_addr <= br ? branch_target : pc_4;
            state      <= FETCH;
          end
      endcase
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (fetch_valid && !stall && !br && fetch_count != '1) fetch_count <= fetch_count + 32'd1;
      if ((state == DISCARD || (state == FETCH && ibw)) && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed scenarios plus randomized run against a behavioural fetch model and an in-order stream checker.
module tb_pc_fetch_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        br = 1'b0, dbw = 1'b0, hold = 1'b0, ibw = 1'b0;
  logic [31:0] tgt = '0;
  logic [31:0] pc_out, pc_4_out, instr;
  logic        bw_imem;
  int          n_tests = 0, n_fail = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count;
`endif
  pc_fetch_unit_if #(.ADDR_W(32)) bus ();
  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction
  assign bus.imem_readdata = mem(bus.imem_addr);
  assign bus.imem_busywait = ibw;
  pc_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .branch_jump_signal(br), .branch_target(tgt),
    .busywait(dbw), .hold(hold), .imem(bus),
    .pc_out(pc_out), .pc_4_out(pc_4_out), .instruction_out(instr), .busywait_imem(bw_imem)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  task automatic goto_pc(input logic [31:0] a);
    br = 1; tgt = a; ibw = 0; dbw = 0; hold = 0;
    @(negedge clk);
    br = 0;
  endtask
  task automatic test_reset();
    @(negedge clk); #1;
    n_tests++; if (bus.imem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got %b want 0", bus.imem_read); end
    n_tests++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h want 0", instr); end
    n_tests++; if (bw_imem !== 1'b1) begin n_fail++; $display("FAIL reset_busy got %b want 1", bw_imem); end
    n_tests++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", pc_out); end
  endtask
  task automatic test_sequential();
    @(negedge clk); reset = 0; br = 1; tgt = 32'h500; #1;
    n_tests++; if (bus.imem_read !== 1'b0) begin n_fail++; $display("FAIL rst_state_read got %b want 0", bus.imem_read); end
    @(negedge clk); br = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.imem_addr !== 32'(4*i)) begin n_fail++; $display("FAIL seq_addr got %h want %h", bus.imem_addr, 32'(4*i)); end
      n_tests++; if (pc_out !== 32'(4*i) || pc_4_out !== 32'(4*i+4)) begin n_fail++; $display("FAIL seq_pc got %h/%h want %h/%h", pc_out, pc_4_out, 32'(4*i), 32'(4*i+4)); end
      n_tests++; if (bw_imem !== 1'b0 || instr !== mem(32'(4*i))) begin n_fail++; $display("FAIL seq_instr got %b/%h want 0/%h", bw_imem, instr, mem(32'(4*i))); end
      @(negedge clk);
    end
  endtask
  task automatic test_wait();
    goto_pc(32'h10);
    ibw = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (bus.imem_addr !== 32'h10 || bus.imem_read !== 1'b1) begin n_fail++; $display("FAIL wait_addr got %h/%b want 10/1", bus.imem_addr, bus.imem_read); end
      n_tests++; if (instr !== 32'h0 || bw_imem !== 1'b1) begin n_fail++; $display("FAIL wait_instr got %h/%b want 0/1", instr, bw_imem); end
      @(negedge clk);
    end
    ibw = 0; #1;
    n_tests++; if (instr !== mem(32'h10) || bw_imem !== 1'b0) begin n_fail++; $display("FAIL wait_done got %h/%b want %h/0", instr, bw_imem, mem(32'h10)); end
    @(negedge clk); #1;
    n_tests++; if (pc_out !== 32'h14 || bus.imem_addr !== 32'h14) begin n_fail++; $display("FAIL wait_next got %h/%h want 14", pc_out, bus.imem_addr); end
  endtask
  task automatic test_discard();
    goto_pc(32'h20);
    ibw = 1; br = 1; tgt = 32'h200; #1;
    n_tests++; if (instr !== 32'h0 || bus.imem_addr !== 32'h20) begin n_fail++; $display("FAIL disc_first got %h/%h want 0/20", instr, bus.imem_addr); end
    @(negedge clk); br = 0;
    for (int i = 0; i < 3; i++) begin
      ibw = (i < 2); #1;
      n_tests++; if (bus.imem_addr !== 32'h20 || bus.imem_read !== 1'b1) begin n_fail++; $display("FAIL disc_addr got %h/%b want 20/1", bus.imem_addr, bus.imem_read); end
      n_tests++; if (instr !== 32'h0 || bw_imem !== 1'b1) begin n_fail++; $display("FAIL disc_instr got %h/%b want 0/1", instr, bw_imem); end
      @(negedge clk);
    end
    ibw = 0; #1;
    n_tests++; if (bus.imem_addr !== 32'h200 || instr !== mem(32'h200)) begin n_fail++; $display("FAIL disc_redirect got %h/%h want 200/%h", bus.imem_addr, instr, mem(32'h200)); end
    @(negedge clk);
  endtask
  task automatic test_hold();
    goto_pc(32'h30);
    hold = 1; @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      hold = (i == 0); #1;
      n_tests++; if (bus.imem_read !== 1'b0 || bw_imem !== 1'b0) begin n_fail++; $display("FAIL hold_read got %b/%b want 0/0", bus.imem_read, bw_imem); end
      n_tests++; if (instr !== mem(32'h30) || pc_out !== 32'h30) begin n_fail++; $display("FAIL hold_buf got %h/%h want %h/30", instr, pc_out, mem(32'h30)); end
      @(negedge clk);
    end
    #1;
    n_tests++; if (bus.imem_addr !== 32'h34 || bus.imem_read !== 1'b1) begin n_fail++; $display("FAIL hold_next got %h/%b want 34/1", bus.imem_addr, bus.imem_read); end
  endtask
  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC); #1;
    n_tests++; if (bus.imem_addr !== 32'hFFFF_FFFC || pc_4_out !== 32'h0) begin n_fail++; $display("FAIL wrap_pc4 got %h/%h want fffffffc/0", bus.imem_addr, pc_4_out); end
    @(negedge clk); #1;
    n_tests++; if (bus.imem_addr !== 32'h0 || pc_out !== 32'h0) begin n_fail++; $display("FAIL wrap_next got %h/%h want 0", bus.imem_addr, pc_out); end
  endtask
  task automatic test_async_reset();
    goto_pc(32'h40);
    ibw = 1; #1;
    n_tests++; if (bus.imem_read !== 1'b1) begin n_fail++; $display("FAIL areset_pre got %b want 1", bus.imem_read); end
    reset = 1; #1;
    n_tests++; if (bus.imem_read !== 1'b0 || pc_out !== 32'h0 || bw_imem !== 1'b1) begin n_fail++; $display("FAIL areset_now got %b/%h/%b want 0/0/1", bus.imem_read, pc_out, bw_imem); end
`ifdef FETCH_PERF_CNT_EN
    n_tests++; if (fetch_count !== 32'h0 || stall_count !== 32'h0) begin n_fail++; $display("FAIL areset_cnt got %h/%h want 0/0", fetch_count, stall_count); end
`endif
    @(negedge clk);
    ibw = 0;
  endtask
  task automatic test_random();
    logic        run, held, stale, v, st, pread, pbw;
    logic [31:0] mpc, maddr, mbuf, nxt, paddr, ei, fc, sc;
    reset = 1; br = 0; hold = 0; dbw = 0; ibw = 0;
    @(negedge clk);
    reset = 0;
    run = 0; held = 0; stale = 0; pread = 0; pbw = 0;
    mpc = 0; maddr = 0; mbuf = 0; nxt = 0; paddr = 0; fc = 0; sc = 0;
    for (int i = 0; i < 600; i++) begin
      ibw  = ($urandom_range(0, 9) < 4);
      br   = ($urandom_range(0, 9) == 0);
      tgt  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'h0000_FFFC);
      dbw  = ($urandom_range(0, 9) == 0);
      hold = ($urandom_range(0, 9) == 0);
      #1;
      st = dbw | hold;
      v  = held | (run & ~stale & ~ibw);
      ei = held ? mbuf : v ? mem(maddr) : 32'h0;
      n_tests++; if (bus.imem_read !== (run & ~held)) begin n_fail++; $display("FAIL rnd_read cyc %0d got %b want %b", i, bus.imem_read, run & ~held); end
      n_tests++; if (bus.imem_read && bus.imem_addr !== maddr) begin n_fail++; $display("FAIL rnd_addr cyc %0d got %h want %h", i, bus.imem_addr, maddr); end
      n_tests++; if (instr !== ei || bw_imem !== ~v) begin n_fail++; $display("FAIL rnd_instr cyc %0d got %h/%b want %h/%b", i, instr, bw_imem, ei, ~v); end
      n_tests++; if (pc_out !== mpc || pc_4_out !== mpc + 32'd4) begin n_fail++; $display("FAIL rnd_pc cyc %0d got %h/%h want %h/%h", i, pc_out, pc_4_out, mpc, mpc + 32'd4); end
      n_tests++; if (pread && pbw && bus.imem_read && bus.imem_addr !== paddr) begin n_fail++; $display("FAIL rnd_handshake cyc %0d got %h want %h", i, bus.imem_addr, paddr); end
      if (v && !st && !br) begin
        n_tests++; if (pc_out !== nxt || instr !== mem(nxt)) begin n_fail++; $display("FAIL rnd_stream cyc %0d got %h/%h want %h/%h", i, pc_out, instr, nxt, mem(nxt)); end
        nxt = nxt + 32'd4;
      end else if (run && br) nxt = tgt;
`ifdef FETCH_PERF_CNT_EN
      n_tests++; if (fetch_count !== fc || stall_count !== sc) begin n_fail++; $display("FAIL rnd_cnt cyc %0d got %h/%h want %h/%h", i, fetch_count, stall_count, fc, sc); end
      fc = fc + 32'(v & ~st & ~br);
      sc = sc + 32'(run & ~held & (stale | ibw));
`endif
      pread = bus.imem_read; pbw = ibw; paddr = bus.imem_addr;
      if (!run) run = 1;
      else if (held) begin
        if (br) begin mpc = tgt; maddr = tgt; held = 0; end
        else if (!st) begin mpc = mpc + 32'd4; maddr = mpc; held = 0; end
      end else if (stale) begin
        if (br) mpc = tgt;
        if (!ibw) begin maddr = mpc; stale = 0; end
      end else if (br) begin
        mpc = tgt;
        if (ibw) stale = 1; else maddr = tgt;
      end else if (!ibw) begin
        if (st) begin held = 1; mbuf = mem(maddr); end
        else begin mpc = mpc + 32'd4; maddr = mpc; end
      end
      @(negedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_sequential();
    test_wait();
    test_discard();
    test_hold();
    test_wrap();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
